// File: rtl/truth_table_sweeper.sv
// Self-check sequencer for the F(A,B,C,D) = PI M(0,1,2,8,10,12,14) function unit:
// sweeps ABCD 0..15, samples F after a settle time and compares against a golden table.
module truth_table_sweeper #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'hAAF8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail,
    output logic        pass
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // With no settle time every vector goes straight to SAMPLE.
    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam state_t     FIRST_STATE = (SETTLE > 0) ? S_WAIT : S_SAMPLE;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  cnt_r;
    logic        miss_s;
    logic [4:0]  count_next_s;

    // Next-state logic and the per-sample mismatch evaluation.
    always_comb begin
        state_next_s = state_r;
        miss_s       = f_in ^ EXPECTED[abcd];
        count_next_s = mismatch_count + {4'd0, miss_s};
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = FIRST_STATE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_next_s = S_SAMPLE;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_SAMPLE: begin
                if (abcd == 4'd15) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = FIRST_STATE;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered vector, settle counter and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            abcd           <= 4'd0;
            cnt_r          <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            table_out      <= 16'd0;
            mismatch_count <= 5'd0;
            first_fail     <= 4'd0;
            pass           <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    abcd <= 4'd0;
                    if (start) begin
                        cnt_r          <= 4'd0;
                        busy           <= 1'b1;
                        table_out      <= 16'd0;
                        mismatch_count <= 5'd0;
                        first_fail     <= 4'd0;
                        pass           <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cnt_r <= cnt_r + 4'd1;
                end
                S_SAMPLE: begin
                    table_out[abcd] <= f_in;
                    mismatch_count  <= count_next_s;
                    // Only the first mismatch of the sweep records its index.
                    if (miss_s && (mismatch_count == 5'd0)) begin
                        first_fail <= abcd;
                    end
                    if (abcd != 4'd15) begin
                        abcd  <= abcd + 4'd1;
                        cnt_r <= 4'd0;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        pass <= (count_next_s == 5'd0);
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    abcd <= 4'd0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (SETTLE 0, 1, 15) each driving a modelled
// function unit whose output can be corrupted per vector by a fault mask.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       start;
    logic [2:0][15:0] fault;

    wire [2:0]       f_in;
    wire [2:0][3:0]  abcd;
    wire [2:0]       busy;
    wire [2:0]       done;
    wire [2:0]       pass;
    wire [2:0][15:0] table_out;
    wire [2:0][4:0]  mismatch_count;
    wire [2:0][3:0]  first_fail;

    int errors = 0;
    int checks = 0;

    // F is 0 exactly on the maxterms 0,1,2,8,10,12,14.
    function automatic logic golden_f(input logic [3:0] v);
        return !(v inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd10, 4'd12, 4'd14});
    endfunction

    function automatic int settle_of(input int u);
        return (u == 0) ? 0 : ((u == 1) ? 1 : 15);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 0 : ((g == 1) ? 1 : 15);
        assign f_in[g] = golden_f(abcd[g]) ^ fault[g][abcd[g]];
        truth_table_sweeper #(.SETTLE(S), .EXPECTED(16'hAAF8)) dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start[g]),
            .f_in           (f_in[g]),
            .abcd           (abcd[g]),
            .busy           (busy[g]),
            .done           (done[g]),
            .table_out      (table_out[g]),
            .mismatch_count (mismatch_count[g]),
            .first_fail     (first_fail[g]),
            .pass           (pass[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: table = F xor fault; every faulted bit is a mismatch against F.
    task automatic model(input logic [15:0] flt, output logic [15:0] tab,
                         output int cnt, output int first);
        tab = 16'd0;
        cnt = 0;
        first = 0;
        for (int i = 0; i < 16; i++) begin
            logic o;
            o = golden_f(4'(i)) ^ flt[i];
            tab[i] = o;
            if (o != golden_f(4'(i))) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endtask

    task automatic sweep(input int u, input logic [15:0] flt, input logic hold,
                         input logic [15:0] e_tab, input int e_cnt, input int e_first,
                         input logic e_pass);
        int s;
        int t;
        int seq_bad;
        s = settle_of(u);
        t = 0;
        seq_bad = 0;
        fault[u] = flt;
        start[u] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start[u] = 1'b0;
        while (done[u] !== 1'b1 && t < 400) begin
            if (abcd[u] !== 4'(t / (s + 1)) || busy[u] !== 1'b1) seq_bad++;
            @(posedge clk); #1;
            t++;
        end
        chk("latency", t, 16 * (s + 1));
        chk("abcd_busy_seq", seq_bad, 0);
        chk("done_abcd", abcd[u], 15);
        chk("done_busy", busy[u], 0);
        chk("table_out", table_out[u], e_tab);
        chk("mismatch_count", mismatch_count[u], e_cnt);
        chk("first_fail", first_fail[u], e_first);
        chk("pass", pass[u], e_pass);
        @(posedge clk); #1;
        start[u] = 1'b0;
        chk("done_pulse", done[u], 0);
        chk("idle_abcd", abcd[u], 0);
        chk("idle_busy", busy[u], 0);
        repeat (2) @(posedge clk);
        #1;
        chk("no_restart_busy", busy[u], 0);
        chk("hold_table", table_out[u], e_tab);
        chk("hold_pass", pass[u], e_pass);
    endtask

    typedef struct {
        int          unit;
        logic [15:0] flt;
        logic        hold;
        logic [15:0] tab;
        int          cnt;
        int          first;
        logic        pass;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] r_flt;
        logic [15:0] r_tab;
        int          r_cnt;
        int          r_first;
        int          r_unit;
        int          t;

        vecs[0] = '{1, 16'h0000, 1'b0, 16'hAAF8, 0, 0, 1'b1};
        vecs[1] = '{1, 16'hAAF8, 1'b0, 16'h0000, 9, 3, 1'b0};
        vecs[2] = '{1, 16'hFFFF, 1'b0, 16'h5507, 16, 0, 1'b0};
        vecs[3] = '{1, 16'h0000, 1'b1, 16'hAAF8, 0, 0, 1'b1};
        vecs[4] = '{0, 16'h0000, 1'b0, 16'hAAF8, 0, 0, 1'b1};
        vecs[5] = '{2, 16'h0000, 1'b0, 16'hAAF8, 0, 0, 1'b1};
        vecs[6] = '{0, 16'hFFFF, 1'b0, 16'h5507, 16, 0, 1'b0};
        vecs[7] = '{2, 16'hAAF8, 1'b0, 16'h0000, 9, 3, 1'b0};

        rst = 1'b1;
        start = 3'b000;
        fault = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_abcd", abcd[1], 0);
        chk("rst_busy", busy[1], 0);
        chk("rst_done", done[1], 0);
        chk("rst_table", table_out[1], 0);
        chk("rst_count", mismatch_count[1], 0);
        chk("rst_first", first_fail[1], 0);
        chk("rst_pass", pass[1], 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            sweep(vecs[i].unit, vecs[i].flt, vecs[i].hold, vecs[i].tab,
                  vecs[i].cnt, vecs[i].first, vecs[i].pass);
        end

        // Reset mid-sweep at vector 7 discards the partial result.
        fault[1] = 16'h0000;
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        t = 0;
        while (abcd[1] !== 4'd7 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("reach_abcd7", abcd[1], 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_abcd", abcd[1], 0);
        chk("midrst_busy", busy[1], 0);
        chk("midrst_table", table_out[1], 0);
        chk("midrst_count", mismatch_count[1], 0);
        chk("midrst_first", first_fail[1], 0);
        chk("midrst_pass_done", {pass[1], done[1]}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_idle_busy", busy[1], 0);
        sweep(1, 16'h0000, 1'b0, 16'hAAF8, 0, 0, 1'b1);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        start[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start[1] = 1'b0;
        chk("prio_busy", busy[1], 0);
        @(posedge clk); #1;
        chk("prio_busy_later", busy[1], 0);
        chk("prio_abcd", abcd[1], 0);

        for (int n = 0; n < 6; n++) begin
            r_unit = int'($urandom_range(0, 2));
            r_flt = 16'($urandom);
            model(r_flt, r_tab, r_cnt, r_first);
            sweep(r_unit, r_flt, 1'b0, r_tab, r_cnt, r_first, (r_cnt == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencing controller for the four-input gate-level function unit F(A,B,C,D) = ΠM(0,1,2,8,10,12,14). On a start request it drives every input combination 0000..1111 onto the unit's A,B,C,D pins and waits a programmable settle time before sampling F. It records the 16-bit truth table and checks it against an expected mask, reporting mismatch count and the first failing index. It replaces the free-running stimulus loop with a synthesizable self-check that other blocks can trigger and poll.

## Interface
- SETTLE, 1, wait cycles per vector before sampling; legal range 0..15.
- EXPECTED, 16'hAAF8, golden truth table; bit i = F at ABCD=i. F=1 at 3,4,5,6,7,9,11,13,15.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  sweep request; sampled only in IDLE.
- f_in  in  1  F output of the function unit.
- abcd  out  4  vector driven to the unit; abcd[3]=A … abcd[0]=D.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when results are valid.
- table_out  out  16  captured truth table.
- mismatch_count  out  5  number of bits where table_out differs from EXPECTED (0..16).
- first_fail  out  4  lowest index that mismatches; 0 when there is no mismatch.
- pass  out  1  high when mismatch_count==0 at done; held afterwards.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE: start=1 → abcd←0, settle counter←0, table_out/mismatch_count/first_fail/pass←0, busy←1. Next state is WAIT if SETTLE>0, otherwise SAMPLE.
- WAIT: the counter increments each cycle. When it reaches SETTLE-1, go to SAMPLE.
- SAMPLE: at the end of the cycle:
  - table_out[abcd]←f_in.
  - If f_in≠EXPECTED[abcd]: mismatch_count increments. first_fail←abcd if this is the first mismatch of the sweep.
  - If abcd≠15: abcd←abcd+1, counter←0, return to WAIT (or SAMPLE if SETTLE=0).
  - If abcd=15: go to DONE, abcd holds 15.
- DONE: lasts one cycle. done=1, busy=0, pass=(mismatch_count==0). Returns to IDLE. start is ignored in DONE.
- IDLE after a sweep: abcd returns to 0. table_out, mismatch_count, first_fail and pass hold until the next accepted start or reset.
- start while busy or in DONE: ignored, with no effect on the sweep in progress.
- abcd is 4-bit and never wraps during a sweep. The 15→0 transition happens only via IDLE.
- mismatch_count is 5-bit and saturates naturally at 16, so overflow is impossible.

## Timing
- Reset values: abcd=0, busy=0, done=0, table_out=0, mismatch_count=0, first_fail=0, pass=0, state=IDLE.
- Reset mid-sweep: everything returns to the reset values on the next edge. No partial result is retained.
- Start accepted at edge k: busy=1 and abcd=0 after edge k.
- Vector i is sampled at edge k+(i+1)(SETTLE+1).
- abcd is stable for SETTLE+1 cycles before each sample.
- done=1 after edge k+16(SETTLE+1); done=0 one edge later.
- For SETTLE=1: done follows start acceptance by 32 cycles.
- Outputs are registered. f_in is treated as combinational from abcd and must settle within SETTLE+1 cycles.
- rst has priority over start in the same cycle.

## Test plan
- Golden unit, SETTLE=1, start pulse → abcd steps 0..15, each held 2 cycles. done 32 cycles after acceptance. table_out=16'hAAF8, mismatch_count=0, first_fail=0, pass=1.
- f_in tied 0 → table_out=16'h0000, mismatch_count=9, first_fail=3, pass=0.
- f_in = ~F → table_out=16'h5507, mismatch_count=16, first_fail=0, pass=0.
- start held high for the entire sweep plus the DONE cycle → exactly one sweep. A new sweep starts only from IDLE, one cycle after done.
- rst asserted when abcd=7 → next edge all outputs 0 and busy=0. A subsequent start gives a full correct sweep (0xAAF8, pass=1).
- SETTLE=0, golden unit → one vector per cycle, done 16 cycles after acceptance, pass=1. Repeat with SETTLE=15 → done after 256 cycles.
